iob_cache_replacement_engine: RTL and testbench
===============================================

# iob_cache_replacement_engine

Parametrised victim-selection engine for the set-associative cache, successor to the single-policy replacement block. It holds per-line replacement state in an internal register array, serves registered victim-selection requests from the miss path, and takes hit/fill updates from the access path. It adds invalid-way-first selection, per-way lock masking, a pseudo-random policy and a sequential state-flush sweep.

## Interface
- N_WAYS, 8: associativity; power of two, 2..16
- NLINES_W, 7: line-address width; state array depth 2**NLINES_W
- NWAYS_W, $clog2(N_WAYS): way-index width
- REP_POLICY, `IOB_CACHE_PLRU_TREE: one of `IOB_CACHE_LRU, `IOB_CACHE_PLRU_MRU, `IOB_CACHE_PLRU_TREE, `IOB_CACHE_RANDOM
- LFSR_SEED, 16'hACE1: nonzero seed of the 16-bit random LFSR

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- cke_i  in  1  clock enable; when low, no state, FSM, LFSR or output changes
- sel_valid_i  in  1  victim request
- sel_ready_o  out  1  request accepted when high with sel_valid_i
- sel_line_i  in  NLINES_W  line of request
- valid_ways_i  in  N_WAYS  valid bits of that line, sampled with request
- lock_mask_i  in  N_WAYS  1 = way may not be chosen
- sel_valid_o  out  1  one-cycle response strobe
- sel_way_o  out  N_WAYS  one-hot victim
- sel_way_bin_o  out  NWAYS_W  binary victim
- sel_none_o  out  1  all ways locked; sel_way_o is zero
- upd_valid_i  in  1  access update (hit or fill)
- upd_line_i  in  NLINES_W  line updated
- upd_way_i  in  N_WAYS  one-hot way accessed
- flush_i  in  1  pulse: reinitialise all line states
- busy_o  out  1  flush sweep in progress

## Operation
- FSM: IDLE, FLUSH. IDLE->FLUSH on flush_i. FLUSH writes the init state to line cnt and increments cnt from 0. FLUSH->IDLE after line 2**NLINES_W-1 is written. flush_i is ignored while in FLUSH.
- sel_ready_o = (state==IDLE). busy_o = (state==FLUSH). upd_valid_i is dropped in FLUSH.
- Init state per line:
  - LRU: age[i]=i.
  - PLRU_MRU: all bits 0.
  - PLRU_TREE: all N_WAYS-1 node bits 0.
  - RANDOM: no per-line state.
- Async reset loads the init state into every line, sets the FSM to IDLE, sets the LFSR to LFSR_SEED and clears all outputs to 0.
- Update (upd_way_i nonzero; all-zero is a no-op):
  - LRU: the accessed way's age becomes N_WAYS-1. Ways with age above the old age of the accessed way decrement.
  - PLRU_MRU: bits |= way. If the result is all ones, bits = way.
  - PLRU_TREE: every node on the path points away from the accessed way (node 0 = left).
- Selection, first match wins:
  1. If any unlocked invalid way exists, choose the lowest-index unlocked invalid way.
  2. Otherwise take the policy candidate:
     - LRU: the way with age 0.
     - PLRU_MRU: the lowest-index way with bit 0.
     - PLRU_TREE: traverse from the root.
     - RANDOM: LFSR[NWAYS_W-1:0].
  3. If the candidate is locked, choose the lowest-index unlocked way.
  4. If all ways are locked, sel_none_o=1 and sel_way_o=0.
- LFSR: x^16+x^14+x^13+x^11+1. It advances once per accepted request.
- Selection does not modify state. Only upd_* writes state.

## Timing
- Request accepted at edge N; sel_valid_o and the way outputs are valid in cycle N+1 for exactly one cycle. Way outputs hold their value until the next response.
- Back-to-back requests are allowed every cycle; there is no output backpressure.
- An update at edge N is visible to requests accepted at edge N+1 or later.
- Same-cycle upd_valid_i and accepted request to the same line: selection uses the post-update state (forwarded).
- Same-cycle update and request to different lines: the two are independent.
- A flush sweep takes exactly 2**NLINES_W cycles; sel_ready_o rises in the cycle after the last write.
- A request presented on the same edge as flush_i is accepted; the sweep starts the next cycle.
- Reset asserted mid-sweep: the FSM returns to IDLE, all lines are re-initialised and any pending response is cancelled.

## Structure
- Extend iob_cache_conf.vh with `IOB_CACHE_RANDOM.
- Shared package iob_cache_rep_pkg holds:
  - the policy encodings
  - per-policy state widths (LRU N_WAYS*NWAYS_W, MRU N_WAYS, TREE N_WAYS-1, RANDOM 0)
  - FSM state constants.
- One sub-module is natural: iob_cache_rep_next_state. It is combinational and contains, per policy, the update function, the candidate decode and the init vector.
- Reuse iob_cache_onehot_to_bin for sel_way_bin_o.

## Test plan
- PLRU_TREE, N_WAYS=4, all valid, no locks; updates to ways 0,1,2,3 on line 5; request line 5 -> sel_way_o=4'b0001.
- LRU, N_WAYS=4; updates to ways 2,0,3,1 on line 0; request -> way 2. Then update way 2; request -> way 0.
- valid_ways_i=8'b1111_0111, lock_mask_i=0 -> way 3 for any policy.
- lock_mask_i=8'hFF -> sel_none_o=1, sel_way_o=0. Then lock_mask_i=8'hFE with a locked candidate -> way 0.
- NLINES_W=3; flush_i pulse -> busy_o high for 8 cycles and sel_ready_o low. Afterwards, requests on every line return the init-state victim (way 0).
- Same-cycle update of way 0 and request on line 1 (PLRU_MRU, N_WAYS=2, init) -> way 1 (forwarded). RANDOM: 20 requests match the golden LFSR sequence from 16'hACE1.

Source files
------------

// File: rtl/iob_cache_rep_pkg.sv
// Shared definitions for the cache replacement engine: policy codes, state widths, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package iob_cache_rep_pkg;

  // Policy encodings, mirroring the cache configuration macros
  localparam int IOB_CACHE_LRU       = 0;
  localparam int IOB_CACHE_PLRU_MRU  = 1;
  localparam int IOB_CACHE_PLRU_TREE = 2;
  localparam int IOB_CACHE_RANDOM    = 3;

  // Sweep controller states
  typedef enum logic {
    REP_IDLE  = 1'b0,
    REP_FLUSH = 1'b1
  } rep_fsm_t;

  // Per-line replacement state width for a given policy (0 = no per-line state)
  function automatic int rep_state_w(input int policy, input int n_ways, input int nways_w);
    case (policy)
      IOB_CACHE_LRU:       return n_ways * nways_w;
      IOB_CACHE_PLRU_MRU:  return n_ways;
      IOB_CACHE_PLRU_TREE: return n_ways - 1;
      default:             return 0;
    endcase
  endfunction

endpackage

// File: rtl/iob_cache_onehot_to_bin.sv
// One-hot to binary index encoder.
// Latency: combinational.
// Backpressure: none.
module iob_cache_onehot_to_bin #(
  parameter int N_WAYS  = 8,
  parameter int NWAYS_W = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0]  onehot,
  output logic [NWAYS_W-1:0] bin
);

  // OR together the indices of all set bits; exact for a one-hot or zero input
  always_comb begin
    bin = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (onehot[i]) bin = bin | NWAYS_W'(i);
    end
  end

endmodule

// File: rtl/iob_cache_rep_next_state.sv
// Per-policy replacement logic: update function, victim candidate decode, init vector.
// Latency: combinational.
// Backpressure: none.
module iob_cache_rep_next_state
  import iob_cache_rep_pkg::*;
#(
  parameter int N_WAYS     = 8,
  parameter int NWAYS_W    = $clog2(N_WAYS),
  parameter int REP_POLICY = IOB_CACHE_PLRU_TREE,
  parameter int SW         = 1
) (
  input  logic [SW-1:0]     upd_cur,
  input  logic [N_WAYS-1:0] upd_way,
  output logic [SW-1:0]     upd_nxt,
  input  logic [SW-1:0]     cand_cur,
  output logic [N_WAYS-1:0] cand_way,
  output logic [SW-1:0]     init_st
);

  if (REP_POLICY == IOB_CACHE_LRU) begin : g_lru
    // Ages packed NWAYS_W bits per way; age 0 is least recently used
    always_comb begin
      logic [NWAYS_W-1:0] old_age;
      logic [NWAYS_W-1:0] age;
      old_age  = '0;
      age      = '0;
      upd_nxt  = upd_cur;
      cand_way = '0;
      init_st  = '0;
      for (int i = 0; i < N_WAYS; i++) begin
        init_st[i*NWAYS_W +: NWAYS_W] = NWAYS_W'(i);
        if (upd_way[i]) old_age = old_age | upd_cur[i*NWAYS_W +: NWAYS_W];
        if (cand_cur[i*NWAYS_W +: NWAYS_W] == '0) cand_way[i] = 1'b1;
      end
      if (|upd_way) begin
        for (int i = 0; i < N_WAYS; i++) begin
          age = upd_cur[i*NWAYS_W +: NWAYS_W];
          if (upd_way[i]) upd_nxt[i*NWAYS_W +: NWAYS_W] = NWAYS_W'(N_WAYS - 1);
          else if (age > old_age) upd_nxt[i*NWAYS_W +: NWAYS_W] = age - NWAYS_W'(1);
        end
      end
    end
  end else if (REP_POLICY == IOB_CACHE_PLRU_MRU) begin : g_mru
    // One MRU bit per way; when every bit would be set, restart from the accessed way
    always_comb begin
      logic found;
      found    = 1'b0;
      init_st  = '0;
      cand_way = '0;
      upd_nxt  = upd_cur;
      if (|upd_way) begin
        upd_nxt = upd_cur | upd_way;
        if (&upd_nxt) upd_nxt = upd_way;
      end
      for (int i = 0; i < N_WAYS; i++) begin
        if (!found && !cand_cur[i]) begin
          cand_way[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end else if (REP_POLICY == IOB_CACHE_PLRU_TREE) begin : g_tree
    // Heap-ordered node bits (node k has children 2k+1, 2k+2); bit 0 points left.
    // Each way's path is evaluated with constant indices so no dynamic bit selects are needed.
    always_comb begin
      logic match;
      match    = 1'b0;
      init_st  = '0;
      cand_way = '0;
      upd_nxt  = upd_cur;
      for (int w = 0; w < N_WAYS; w++) begin
        match = 1'b1;
        for (int l = 0; l < NWAYS_W; l++) begin
          if (upd_way[w])
            upd_nxt[(1 << l) - 1 + (w >> (NWAYS_W - l))] = (((w >> (NWAYS_W - 1 - l)) & 1) == 0);
          if (cand_cur[(1 << l) - 1 + (w >> (NWAYS_W - l))] != (((w >> (NWAYS_W - 1 - l)) & 1) != 0))
            match = 1'b0;
        end
        cand_way[w] = match;
      end
    end
  end else begin : g_random
    // No per-line state; the candidate comes from the LFSR in the top level
    always_comb begin
      upd_nxt  = upd_cur;
      cand_way = '0;
      init_st  = '0;
    end
  end

endmodule

// File: rtl/iob_cache_replacement_engine.sv
// Victim selection engine with per-line replacement state, lock masking and flush sweep.
// Latency: one cycle from accepted request to sel_valid_o; updates visible next cycle (forwarded same line).
// Backpressure: sel_ready_o low during flush sweep; no output backpressure.
module iob_cache_replacement_engine
  import iob_cache_rep_pkg::*;
#(
  parameter int          N_WAYS     = 8,
  parameter int          NLINES_W   = 7,
  parameter int          NWAYS_W    = $clog2(N_WAYS),
  parameter int          REP_POLICY = IOB_CACHE_PLRU_TREE,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                sel_valid_i,
  output logic                sel_ready_o,
  input  logic [NLINES_W-1:0] sel_line_i,
  input  logic [N_WAYS-1:0]   valid_ways_i,
  input  logic [N_WAYS-1:0]   lock_mask_i,
  output logic                sel_valid_o,
  output logic [N_WAYS-1:0]   sel_way_o,
  output logic [NWAYS_W-1:0]  sel_way_bin_o,
  output logic                sel_none_o,
  input  logic                upd_valid_i,
  input  logic [NLINES_W-1:0] upd_line_i,
  input  logic [N_WAYS-1:0]   upd_way_i,
  input  logic                flush_i,
  output logic                busy_o
);

  localparam int NLINES = 2 ** NLINES_W;
  localparam int SW_RAW = rep_state_w(REP_POLICY, N_WAYS, NWAYS_W);
  localparam int SW     = (SW_RAW > 0) ? SW_RAW : 1;

  logic [SW-1:0]       mem [NLINES];
  rep_fsm_t            state_q, state_d;
  logic [NLINES_W-1:0] cnt_q;
  logic [15:0]         lfsr_q;
  logic                accept, upd_en, none;
  logic [SW-1:0]       upd_nxt, fwd_st, init_st;
  logic [N_WAYS-1:0]   cand_pol, cand, victim, inv_free, unlocked;
  logic [NWAYS_W-1:0]  victim_bin;

  assign sel_ready_o = (state_q == REP_IDLE);
  assign busy_o      = (state_q == REP_FLUSH);
  assign accept      = cke_i & sel_valid_i & sel_ready_o;
  assign upd_en      = cke_i & upd_valid_i & sel_ready_o & (|upd_way_i);
  // Same-line update in the same cycle is forwarded into the selection
  assign fwd_st      = (upd_en && (upd_line_i == sel_line_i)) ? upd_nxt : mem[sel_line_i];
  assign unlocked    = ~lock_mask_i;
  assign inv_free    = ~valid_ways_i & unlocked;
  assign cand        = (REP_POLICY == IOB_CACHE_RANDOM) ? (N_WAYS'(1) << lfsr_q[NWAYS_W-1:0]) : cand_pol;

  iob_cache_rep_next_state #(
    .N_WAYS(N_WAYS), .NWAYS_W(NWAYS_W), .REP_POLICY(REP_POLICY), .SW(SW)
  ) u_next_state (
    .upd_cur (mem[upd_line_i]),
    .upd_way (upd_way_i),
    .upd_nxt (upd_nxt),
    .cand_cur(fwd_st),
    .cand_way(cand_pol),
    .init_st (init_st)
  );

  iob_cache_onehot_to_bin #(.N_WAYS(N_WAYS), .NWAYS_W(NWAYS_W)) u_bin (
    .onehot(victim),
    .bin   (victim_bin)
  );

  // Victim priority: unlocked invalid way, unlocked policy candidate, any unlocked way, none
  always_comb begin
    victim = '0;
    none   = 1'b0;
    if (|inv_free)                victim = inv_free & (~inv_free + N_WAYS'(1));
    else if (|(cand & unlocked))  victim = cand;
    else if (|unlocked)           victim = unlocked & (~unlocked + N_WAYS'(1));
    else                          none   = 1'b1;
  end

  // Sweep controller next state; flush_i is ignored once sweeping
  always_comb begin
    state_d = state_q;
    case (state_q)
      REP_IDLE:  if (flush_i) state_d = REP_FLUSH;
      REP_FLUSH: if (cnt_q == '1) state_d = REP_IDLE;
      default:   state_d = REP_IDLE;
    endcase
  end

  // FSM, sweep counter and LFSR (advances once per accepted request)
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= REP_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= (state_q == REP_FLUSH) ? cnt_q + NLINES_W'(1) : '0;
      if (accept) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Line state array: sweep writes init, otherwise access updates
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < NLINES; i++) mem[i] <= init_st;
    end else if (cke_i) begin
      if (state_q == REP_FLUSH) mem[cnt_q] <= init_st;
      else if (upd_en)          mem[upd_line_i] <= upd_nxt;
    end
  end

  // Registered response; way outputs hold until the next accepted request
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sel_valid_o   <= 1'b0;
      sel_way_o     <= '0;
      sel_way_bin_o <= '0;
      sel_none_o    <= 1'b0;
    end else if (cke_i) begin
      sel_valid_o <= accept;
      if (accept) begin
        sel_way_o     <= victim;
        sel_way_bin_o <= victim_bin;
        sel_none_o    <= none;
      end
    end
  end

endmodule

// File: tb/tb_iob_cache_replacement_engine.sv
// Directed bench for the replacement engine across all four policies.
// Latency: checks responses one cycle after each accepted request.
// Backpressure: exercises flush sweep request blocking.
module tb_iob_cache_replacement_engine;
  import iob_cache_rep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, cke;
  logic [3:0] sel_v, upd_v, flush;
  logic [2:0] line, upd_line;
  logic [7:0] valid, lock, upd_way;
  logic [3:0] svo, rdy, bsy, none;
  logic [3:0] way_a, way_b;
  logic [1:0] way_c;
  logic [7:0] way_d;
  logic [1:0] bin_a, bin_b;
  logic       bin_c;
  logic [2:0] bin_d;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [15:0] m_lfsr;

  iob_cache_replacement_engine #(.N_WAYS(4), .NLINES_W(3), .REP_POLICY(IOB_CACHE_PLRU_TREE)) u_a (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .sel_valid_i(sel_v[0]), .sel_ready_o(rdy[0]),
    .sel_line_i(line), .valid_ways_i(valid[3:0]), .lock_mask_i(lock[3:0]), .sel_valid_o(svo[0]),
    .sel_way_o(way_a), .sel_way_bin_o(bin_a), .sel_none_o(none[0]), .upd_valid_i(upd_v[0]),
    .upd_line_i(upd_line), .upd_way_i(upd_way[3:0]), .flush_i(flush[0]), .busy_o(bsy[0]));

  iob_cache_replacement_engine #(.N_WAYS(4), .NLINES_W(3), .REP_POLICY(IOB_CACHE_LRU)) u_b (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .sel_valid_i(sel_v[1]), .sel_ready_o(rdy[1]),
    .sel_line_i(line), .valid_ways_i(valid[3:0]), .lock_mask_i(lock[3:0]), .sel_valid_o(svo[1]),
    .sel_way_o(way_b), .sel_way_bin_o(bin_b), .sel_none_o(none[1]), .upd_valid_i(upd_v[1]),
    .upd_line_i(upd_line), .upd_way_i(upd_way[3:0]), .flush_i(flush[1]), .busy_o(bsy[1]));

  iob_cache_replacement_engine #(.N_WAYS(2), .NLINES_W(3), .REP_POLICY(IOB_CACHE_PLRU_MRU)) u_c (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .sel_valid_i(sel_v[2]), .sel_ready_o(rdy[2]),
    .sel_line_i(line), .valid_ways_i(valid[1:0]), .lock_mask_i(lock[1:0]), .sel_valid_o(svo[2]),
    .sel_way_o(way_c), .sel_way_bin_o(bin_c), .sel_none_o(none[2]), .upd_valid_i(upd_v[2]),
    .upd_line_i(upd_line), .upd_way_i(upd_way[1:0]), .flush_i(flush[2]), .busy_o(bsy[2]));

  iob_cache_replacement_engine #(.N_WAYS(8), .NLINES_W(3), .REP_POLICY(IOB_CACHE_RANDOM)) u_d (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .sel_valid_i(sel_v[3]), .sel_ready_o(rdy[3]),
    .sel_line_i(line), .valid_ways_i(valid), .lock_mask_i(lock), .sel_valid_o(svo[3]),
    .sel_way_o(way_d), .sel_way_bin_o(bin_d), .sel_none_o(none[3]), .upd_valid_i(upd_v[3]),
    .upd_line_i(upd_line), .upd_way_i(upd_way), .flush_i(flush[3]), .busy_o(bsy[3]));

  // Single comparison point: counts every check, reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_way(input int i);
    case (i)
      0:       return {4'b0, way_a};
      1:       return {4'b0, way_b};
      2:       return {6'b0, way_c};
      default: return way_d;
    endcase
  endfunction

  function automatic logic [2:0] get_bin(input int i);
    case (i)
      0:       return {1'b0, bin_a};
      1:       return {1'b0, bin_b};
      2:       return {2'b0, bin_c};
      default: return bin_d;
    endcase
  endfunction

  // Golden LFSR x^16+x^14+x^13+x^11+1, shifted once per accepted request
  task automatic lfsr_step();
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int inst, input logic [2:0] ln, input logic [7:0] w);
    upd_v[inst] = 1'b1;
    upd_line    = ln;
    upd_way     = w;
    tick();
    upd_v = '0;
  endtask

  // Issue one request (alongside any update/flush already set up) and check the response
  task automatic req(input int inst, input logic [2:0] ln, input logic [7:0] vw,
                     input logic [7:0] lk, input logic [7:0] exp_way, input string tag);
    logic [2:0] eb;
    eb = '0;
    for (int i = 0; i < 8; i++) if (exp_way[i]) eb = 3'(i);
    sel_v[inst] = 1'b1;
    line  = ln;
    valid = vw;
    lock  = lk;
    tick();
    sel_v = '0;
    upd_v = '0;
    flush = '0;
    check({tag, ".vld"},  {31'b0, svo[inst]}, 32'd1);
    check({tag, ".way"},  {24'b0, get_way(inst)}, {24'b0, exp_way});
    check({tag, ".bin"},  {29'b0, get_bin(inst)}, {29'b0, eb});
    check({tag, ".none"}, {31'b0, none[inst]}, {31'b0, exp_way == 8'h00});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_w;
    int         waited;
    arst_n = 1'b0; cke = 1'b1;
    sel_v = '0; upd_v = '0; flush = '0;
    line = '0; upd_line = '0; valid = '0; lock = '0; upd_way = '0;
    m_lfsr = 16'hACE1;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;

    // Reset state
    check("rst.svo",  {28'b0, svo}, 32'h0);
    check("rst.rdy",  {28'b0, rdy}, 32'hF);
    check("rst.busy", {28'b0, bsy}, 32'h0);
    check("rst.way_d", {24'b0, way_d}, 32'h0);
    check("rst.none", {28'b0, none}, 32'h0);

    // Clock enable low: request is not taken and the LFSR must not move
    cke = 1'b0; sel_v[3] = 1'b1; valid = 8'hFF; lock = 8'h00;
    tick();
    check("cke_off.svo", {31'b0, svo[3]}, 32'd0);
    sel_v = '0; cke = 1'b1;
    tick();

    // PLRU tree: touch all ways of line 5, victim is way 0
    upd(0, 3'd5, 8'h01); upd(0, 3'd5, 8'h02); upd(0, 3'd5, 8'h04); upd(0, 3'd5, 8'h08);
    req(0, 3'd5, 8'h0F, 8'h00, 8'h01, "tree_seq");

    // LRU: access 2,0,3,1 -> way 2 oldest; access 2 -> way 0 oldest
    upd(1, 3'd0, 8'h04); upd(1, 3'd0, 8'h01); upd(1, 3'd0, 8'h08); upd(1, 3'd0, 8'h02);
    req(1, 3'd0, 8'h0F, 8'h00, 8'h04, "lru_a");
    upd(1, 3'd0, 8'h04);
    req(1, 3'd0, 8'h0F, 8'h00, 8'h01, "lru_b");

    // MRU 2-way: same-cycle update of way 0 on the requested line is forwarded
    upd_v[2] = 1'b1; upd_line = 3'd1; upd_way = 8'h01;
    req(2, 3'd1, 8'h03, 8'h00, 8'h02, "mru_fwd");
    req(2, 3'd1, 8'h03, 8'h00, 8'h02, "mru_kept");
    // Update on a different line leaves the requested line independent
    upd_v[2] = 1'b1; upd_line = 3'd2; upd_way = 8'h02;
    req(2, 3'd3, 8'h03, 8'h00, 8'h01, "mru_indep");
    // All bits set collapses to the accessed way only
    upd(2, 3'd1, 8'h02);
    req(2, 3'd1, 8'h03, 8'h00, 8'h01, "mru_wrap");

    // Invalid-way-first, lock masking and all-locked on the 8-way random instance
    req(3, 3'd0, 8'hF7, 8'h00, 8'h08, "inv_first"); lfsr_step();
    req(3, 3'd0, 8'hFF, 8'hFF, 8'h00, "all_locked"); lfsr_step();
    req(3, 3'd0, 8'hFF, 8'hFE, 8'h01, "cand_locked"); lfsr_step();

    // Random policy follows the golden LFSR sequence
    for (int k = 0; k < 20; k++) begin
      exp_w = 8'h01 << m_lfsr[2:0];
      req(3, 3'(k), 8'hFF, 8'h00, exp_w, $sformatf("rand%0d", k));
      lfsr_step();
    end

    // Dirty line 5 of the tree instance, then flush: sweep is exactly 8 cycles
    upd(0, 3'd5, 8'h01);
    req(0, 3'd5, 8'h0F, 8'h00, 8'h04, "tree_pre_flush");
    flush[0] = 1'b1;
    tick();
    flush = '0;
    sel_v[0] = 1'b1; line = 3'd0; valid = 8'h0F; lock = 8'h00;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("flush_busy%0d", c), {31'b0, bsy[0]}, 32'd1);
      check($sformatf("flush_rdy%0d", c),  {31'b0, rdy[0]}, 32'd0);
      check($sformatf("flush_resp%0d", c), {31'b0, svo[0]}, 32'd0);
      tick();
    end
    sel_v = '0;
    check("flush_end.busy", {31'b0, bsy[0]}, 32'd0);
    check("flush_end.rdy",  {31'b0, rdy[0]}, 32'd1);
    check("flush_end.resp", {31'b0, svo[0]}, 32'd0);
    for (int ln = 0; ln < 8; ln++)
      req(0, 3'(ln), 8'h0F, 8'h00, 8'h01, $sformatf("post_flush%0d", ln));

    // Request on the same edge as flush is accepted, sweep follows
    flush[1] = 1'b1;
    req(1, 3'd3, 8'h0F, 8'h00, 8'h01, "req_with_flush");
    check("flush_b.busy", {31'b0, bsy[1]}, 32'd1);
    waited = 0;
    while (!rdy[1] && waited < 20) begin
      tick();
      waited++;
    end
    check("flush_b.done", {31'b0, rdy[1]}, 32'd1);
    req(1, 3'd0, 8'h0F, 8'h00, 8'h01, "lru_after_flush");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
